// File: rtl/cfg_discovery_pkg.sv
// Shared types and constants for the configuration discovery responder.
package cfg_discovery_pkg;

  localparam int unsigned MaxRegionRules = 16;

  typedef enum logic {
    OP_READ   = 1'b0,
    OP_LOOKUP = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [63:0] IDX_ISA          = 64'd0;
  localparam logic [63:0] IDX_UARCH        = 64'd1;
  localparam logic [63:0] IDX_HALT         = 64'd2;
  localparam logic [63:0] IDX_EXC          = 64'd3;
  localparam logic [63:0] IDX_DM           = 64'd4;
  localparam logic [63:0] IDX_RULES        = 64'd5;
  localparam logic [63:0] IDX_EXEC_BASE    = 64'd16;
  localparam logic [63:0] IDX_EXEC_LEN     = 64'd32;
  localparam logic [63:0] IDX_CACHED_BASE  = 64'd48;
  localparam logic [63:0] IDX_CACHED_LEN   = 64'd64;
  localparam logic [63:0] IDX_NONIDEM_BASE = 64'd80;
  localparam logic [63:0] IDX_NONIDEM_LEN  = 64'd96;
  localparam logic [63:0] IDX_LIMIT        = 64'd112;

  localparam int unsigned BIT_EXEC    = 0;
  localparam int unsigned BIT_CACHED  = 1;
  localparam int unsigned BIT_NONIDEM = 2;

  // Scan length is the longest table, but never zero so RESP is always reached.
  function automatic int unsigned scan_len(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration record: the subset of the elaborated CVA6 parameters
// that the discovery responder publishes to software.
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    bit                             RVA;
    bit                             RVB;
    bit                             RVC;
    bit                             RVH;
    bit                             RVV;
    bit                             RVS;
    bit                             RVU;
    bit                             FpuEn;
    bit                             RVZCB;
    bit                             RVSstc;
    bit                             ZiCondExtEn;
    bit                             CvxifEn;
    bit                             DebugEn;
    bit                             TvalEn;
    int unsigned                    NrCommitPorts;
    int unsigned                    NrLoadBufEntries;
    int unsigned                    RASDepth;
    int unsigned                    NrPMPEntries;
    int unsigned                    BTBEntries;
    int unsigned                    BHTEntries;
    logic [63:0]                    HaltAddress;
    logic [63:0]                    ExceptionAddress;
    logic [63:0]                    DmBaseAddress;
    int unsigned                    NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]    NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]    NonIdempotentLength;
    int unsigned                    NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]    ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]    ExecuteRegionLength;
    int unsigned                    NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]    CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]    CachedRegionLength;
    int unsigned                    MaxOutstandingStores;
  } cva6_cfg_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// Default elaborated configuration. Entries past each rule count hold stale
// values on purpose; they must stay invisible to software.
package cva6_config_pkg;

  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    RVA:                   1'b1,
    RVB:                   1'b0,
    RVC:                   1'b1,
    RVH:                   1'b0,
    RVV:                   1'b0,
    RVS:                   1'b1,
    RVU:                   1'b1,
    FpuEn:                 1'b0,
    RVZCB:                 1'b0,
    RVSstc:                1'b0,
    ZiCondExtEn:           1'b0,
    CvxifEn:               1'b0,
    DebugEn:               1'b1,
    TvalEn:                1'b1,
    NrCommitPorts:         32'd2,
    NrLoadBufEntries:      32'd2,
    RASDepth:              32'd2,
    NrPMPEntries:          32'd8,
    BTBEntries:            32'd32,
    BHTEntries:            32'd128,
    HaltAddress:           64'h800,
    ExceptionAddress:      64'h808,
    DmBaseAddress:         64'h0,
    NrNonIdempotentRules:  32'd2,
    NonIdempotentAddrBase: {{13{64'h0}}, 64'h0, 64'h4000_0000, 64'h1000_0000},
    NonIdempotentLength:   {{13{64'h0}}, 64'h100, 64'h1000_0000, 64'h1000},
    NrExecuteRegionRules:  32'd3,
    ExecuteRegionAddrBase: {{13{64'h0}}, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {{13{64'h0}}, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   32'd1,
    CachedRegionAddrBase:  {{14{64'h0}}, 64'h1000, 64'h8000_0000},
    CachedRegionLength:    {{14{64'h0}}, 64'h1000, 64'h4000_0000},
    MaxOutstandingStores:  32'd7
  };

endpackage

// File: rtl/cfg_region_match.sv
// Single region compare: hit when enabled and base <= addr < base + len,
// with the end computed one bit wider so regions touching 2^64 do not wrap.
module cfg_region_match (
  input  logic [63:0] i_addr,
  input  logic [63:0] i_base,
  input  logic [63:0] i_len,
  input  logic        i_en,
  output logic        o_hit
);

  logic [64:0] w_end;

  assign w_end = {1'b0, i_base} + {1'b0, i_len};
  assign o_hit = i_en && (i_addr >= i_base) && ({1'b0, i_addr} < w_end);

endmodule

// File: rtl/cva6_cfg_discovery.sv
// Read-only responder publishing the core configuration words and classifying
// physical addresses against the execute / cached / non-idempotent tables.
//   state   | meaning
//   ST_IDLE | ready for a request
//   ST_SCAN | LOOKUP walking rule index r_k, one rule per cycle
//   ST_RESP | response held until rsp_ready_i
module cva6_cfg_discovery
  import cfg_discovery_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
  parameter int unsigned           IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_op_i,
  input  logic [63:0]        req_addr_i,
  input  logic [IdWidth-1:0] req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [63:0]        rsp_data_o,
  output logic [IdWidth-1:0] rsp_id_o,
  output logic               rsp_err_o,
  output logic               busy_o
);

  localparam int unsigned NrRules = scan_len(CVA6Cfg.NrExecuteRegionRules,
                                             CVA6Cfg.NrCachedRegionRules,
                                             CVA6Cfg.NrNonIdempotentRules);
  localparam logic [3:0]  LastRule = 4'(NrRules - 1);

  state_e             r_state;
  logic [63:0]        r_addr;
  logic [3:0]         r_k;
  logic [2:0]         r_hits;
  logic               r_rsp_valid;
  logic [63:0]        r_rsp_data;
  logic [IdWidth-1:0] r_rsp_id;
  logic               r_rsp_err;

  logic        w_hit_exec, w_hit_cached, w_hit_nonidem;
  logic [2:0]  w_hits_new;
  logic [3:0]  w_slot;
  logic        w_slot_exec, w_slot_cached, w_slot_nonidem;
  logic [63:0] w_rd_data;
  logic        w_rd_err;

  cfg_region_match u_match_exec (
    .i_addr (r_addr),
    .i_base (CVA6Cfg.ExecuteRegionAddrBase[r_k]),
    .i_len  (CVA6Cfg.ExecuteRegionLength[r_k]),
    .i_en   ({28'd0, r_k} < CVA6Cfg.NrExecuteRegionRules),
    .o_hit  (w_hit_exec)
  );

  cfg_region_match u_match_cached (
    .i_addr (r_addr),
    .i_base (CVA6Cfg.CachedRegionAddrBase[r_k]),
    .i_len  (CVA6Cfg.CachedRegionLength[r_k]),
    .i_en   ({28'd0, r_k} < CVA6Cfg.NrCachedRegionRules),
    .o_hit  (w_hit_cached)
  );

  cfg_region_match u_match_nonidem (
    .i_addr (r_addr),
    .i_base (CVA6Cfg.NonIdempotentAddrBase[r_k]),
    .i_len  (CVA6Cfg.NonIdempotentLength[r_k]),
    .i_en   ({28'd0, r_k} < CVA6Cfg.NrNonIdempotentRules),
    .o_hit  (w_hit_nonidem)
  );

  always_comb begin
    w_hits_new              = r_hits;
    w_hits_new[BIT_EXEC]    = r_hits[BIT_EXEC]    | w_hit_exec;
    w_hits_new[BIT_CACHED]  = r_hits[BIT_CACHED]  | w_hit_cached;
    w_hits_new[BIT_NONIDEM] = r_hits[BIT_NONIDEM] | w_hit_nonidem;
  end

  assign w_slot         = req_addr_i[3:0];
  assign w_slot_exec    = {28'd0, w_slot} < CVA6Cfg.NrExecuteRegionRules;
  assign w_slot_cached  = {28'd0, w_slot} < CVA6Cfg.NrCachedRegionRules;
  assign w_slot_nonidem = {28'd0, w_slot} < CVA6Cfg.NrNonIdempotentRules;

  // READ data is decoded straight from the request so it can be registered on accept.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (req_addr_i)
      IDX_ISA:   w_rd_data = {50'd0, CVA6Cfg.TvalEn, CVA6Cfg.DebugEn, CVA6Cfg.CvxifEn,
                              CVA6Cfg.ZiCondExtEn, CVA6Cfg.RVSstc, CVA6Cfg.RVZCB,
                              CVA6Cfg.FpuEn, CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVV,
                              CVA6Cfg.RVH, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
      IDX_UARCH: w_rd_data = {16'(CVA6Cfg.BHTEntries), 16'(CVA6Cfg.BTBEntries),
                              8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.RASDepth),
                              8'(CVA6Cfg.NrLoadBufEntries), 8'(CVA6Cfg.NrCommitPorts)};
      IDX_HALT:  w_rd_data = CVA6Cfg.HaltAddress;
      IDX_EXC:   w_rd_data = CVA6Cfg.ExceptionAddress;
      IDX_DM:    w_rd_data = CVA6Cfg.DmBaseAddress;
      IDX_RULES: w_rd_data = {32'd0, 8'(CVA6Cfg.MaxOutstandingStores),
                              8'(CVA6Cfg.NrCachedRegionRules),
                              8'(CVA6Cfg.NrExecuteRegionRules),
                              8'(CVA6Cfg.NrNonIdempotentRules)};
      default: begin
        if (req_addr_i < IDX_EXEC_BASE || req_addr_i >= IDX_LIMIT) begin
          w_rd_err = 1'b1;
        end else begin
          case (req_addr_i[6:4])
            IDX_EXEC_BASE[6:4]:
              if (w_slot_exec) w_rd_data = CVA6Cfg.ExecuteRegionAddrBase[w_slot];
            IDX_EXEC_LEN[6:4]:
              if (w_slot_exec) w_rd_data = CVA6Cfg.ExecuteRegionLength[w_slot];
            IDX_CACHED_BASE[6:4]:
              if (w_slot_cached) w_rd_data = CVA6Cfg.CachedRegionAddrBase[w_slot];
            IDX_CACHED_LEN[6:4]:
              if (w_slot_cached) w_rd_data = CVA6Cfg.CachedRegionLength[w_slot];
            IDX_NONIDEM_BASE[6:4]:
              if (w_slot_nonidem) w_rd_data = CVA6Cfg.NonIdempotentAddrBase[w_slot];
            IDX_NONIDEM_LEN[6:4]:
              if (w_slot_nonidem) w_rd_data = CVA6Cfg.NonIdempotentLength[w_slot];
            default: w_rd_data = '0;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_k         <= '0;
      r_hits      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_rsp_id <= req_id_i;
            if (op_e'(req_op_i) == OP_LOOKUP) begin
              r_addr  <= req_addr_i;
              r_k     <= '0;
              r_hits  <= '0;
              r_state <= ST_SCAN;
            end else begin
              r_rsp_data  <= w_rd_data;
              r_rsp_err   <= w_rd_err;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_SCAN: begin
          r_hits <= w_hits_new;
          if (r_k == LastRule) begin
            r_rsp_data  <= {61'd0, w_hits_new};
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign busy_o      = (r_state != ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_cva6_cfg_discovery.sv
// Bench for cva6_cfg_discovery: directed vector table, backpressure and
// reset-abort sequences, then random traffic against a reference model.
module tb_cva6_cfg_discovery;

  localparam config_pkg::cva6_cfg_t C = cva6_config_pkg::cva6_cfg;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_op_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic [3:0]  req_id_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_data_o;
  logic [3:0]  rsp_id_o;
  logic        rsp_err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  cva6_cfg_discovery #(.IdWidth(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_addr_i  (req_addr_i),
    .req_id_i    (req_id_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        op;
    logic [63:0] addr;
    logic [3:0]  id;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic op, input logic [63:0] a, input logic [3:0] id,
                     input logic [63:0] d, input logic e);
    vec_t v;
    v.op = op; v.addr = a; v.id = id; v.exp_data = d; v.exp_err = e;
    vecs.push_back(v);
  endtask

  // Reference model: lookup is the union of all live rules of each table.
  function automatic int unsigned model_scan_len();
    int unsigned m;
    m = 1;
    if (C.NrExecuteRegionRules > m) m = C.NrExecuteRegionRules;
    if (C.NrCachedRegionRules > m) m = C.NrCachedRegionRules;
    if (C.NrNonIdempotentRules > m) m = C.NrNonIdempotentRules;
    return m;
  endfunction

  function automatic logic in_region(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] l);
    logic [64:0] lo, hi, x;
    lo = {1'b0, b};
    hi = lo + {1'b0, l};
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [63:0] model_lookup(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(C.NrExecuteRegionRules) &&
          in_region(a, C.ExecuteRegionAddrBase[i], C.ExecuteRegionLength[i])) r[0] = 1'b1;
      if (i < int'(C.NrCachedRegionRules) &&
          in_region(a, C.CachedRegionAddrBase[i], C.CachedRegionLength[i])) r[1] = 1'b1;
      if (i < int'(C.NrNonIdempotentRules) &&
          in_region(a, C.NonIdempotentAddrBase[i], C.NonIdempotentLength[i])) r[2] = 1'b1;
    end
    return r;
  endfunction

  // Returns {err, data} for a READ of word idx.
  function automatic logic [64:0] model_read(input logic [63:0] idx);
    logic [63:0] d;
    logic [63:0] t, i;
    d = '0;
    if (idx == 64'd0) begin
      d = 64'(C.RVA) | (64'(C.RVB) << 1) | (64'(C.RVC) << 2) | (64'(C.RVH) << 3) |
          (64'(C.RVV) << 4) | (64'(C.RVS) << 5) | (64'(C.RVU) << 6) | (64'(C.FpuEn) << 7) |
          (64'(C.RVZCB) << 8) | (64'(C.RVSstc) << 9) | (64'(C.ZiCondExtEn) << 10) |
          (64'(C.CvxifEn) << 11) | (64'(C.DebugEn) << 12) | (64'(C.TvalEn) << 13);
    end else if (idx == 64'd1) begin
      d = (64'(C.NrCommitPorts) % 256) + (64'(C.NrLoadBufEntries) % 256) * 64'h100 +
          (64'(C.RASDepth) % 256) * 64'h1_0000 + (64'(C.NrPMPEntries) % 256) * 64'h100_0000 +
          (64'(C.BTBEntries) % 65536) * 64'h1_0000_0000 +
          (64'(C.BHTEntries) % 65536) * 64'h1_0000_0000_0000;
    end else if (idx == 64'd2) d = C.HaltAddress;
    else if (idx == 64'd3) d = C.ExceptionAddress;
    else if (idx == 64'd4) d = C.DmBaseAddress;
    else if (idx == 64'd5) begin
      d = (64'(C.NrNonIdempotentRules) % 256) + (64'(C.NrExecuteRegionRules) % 256) * 64'h100 +
          (64'(C.NrCachedRegionRules) % 256) * 64'h1_0000 +
          (64'(C.MaxOutstandingStores) % 256) * 64'h100_0000;
    end else if (idx >= 64'd16 && idx < 64'd112) begin
      t = (idx - 64'd16) / 64'd16;
      i = idx % 64'd16;
      case (t)
        64'd0: if (i < 64'(C.NrExecuteRegionRules)) d = C.ExecuteRegionAddrBase[i[3:0]];
        64'd1: if (i < 64'(C.NrExecuteRegionRules)) d = C.ExecuteRegionLength[i[3:0]];
        64'd2: if (i < 64'(C.NrCachedRegionRules)) d = C.CachedRegionAddrBase[i[3:0]];
        64'd3: if (i < 64'(C.NrCachedRegionRules)) d = C.CachedRegionLength[i[3:0]];
        64'd4: if (i < 64'(C.NrNonIdempotentRules)) d = C.NonIdempotentAddrBase[i[3:0]];
        default: if (i < 64'(C.NrNonIdempotentRules)) d = C.NonIdempotentLength[i[3:0]];
      endcase
    end else begin
      return {1'b1, 64'd0};
    end
    return {1'b0, d};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_txn(input logic op, input logic [63:0] addr, input logic [3:0] id,
                         input int ready_delay, output logic [63:0] data, output logic err,
                         output logic [3:0] rid, output int lat);
    int guard;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_id_i    = id;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    chk("req_ready_before_accept", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!rsp_valid_o && lat < 60);
    data = rsp_data_o;
    err  = rsp_err_o;
    rid  = rsp_id_o;
    repeat (ready_delay) @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [63:0] data, a, b, l, exp_d;
    logic [64:0] exp_r;
    logic        err, op;
    logic [3:0]  rid, id;
    int          lat, seen, m;

    m = int'(model_scan_len());

    // READ vectors: expected values written from the default configuration.
    add(1'b0, 64'd0,   4'h5, 64'h3065, 1'b0);
    add(1'b0, 64'd1,   4'h1, 64'h0080_0020_0802_0202, 1'b0);
    add(1'b0, 64'd2,   4'h2, 64'h800, 1'b0);
    add(1'b0, 64'd3,   4'h3, 64'h808, 1'b0);
    add(1'b0, 64'd4,   4'h4, 64'h0, 1'b0);
    add(1'b0, 64'd5,   4'h6, 64'h0701_0302, 1'b0);
    add(1'b0, 64'd17,  4'h7, 64'h1_0000, 1'b0);
    add(1'b0, 64'd18,  4'h8, 64'h8000_0000, 1'b0);
    add(1'b0, 64'd34,  4'h9, 64'h4000_0000, 1'b0);
    add(1'b0, 64'd19,  4'hA, 64'h0, 1'b0);
    add(1'b0, 64'd48,  4'hB, 64'h8000_0000, 1'b0);
    add(1'b0, 64'd49,  4'hC, 64'h0, 1'b0);
    add(1'b0, 64'd81,  4'hD, 64'h4000_0000, 1'b0);
    add(1'b0, 64'd82,  4'hE, 64'h0, 1'b0);
    add(1'b0, 64'd96,  4'hF, 64'h1000, 1'b0);
    add(1'b0, 64'd111, 4'h0, 64'h0, 1'b0);
    add(1'b0, 64'd112, 4'h1, 64'h0, 1'b1);
    add(1'b0, 64'd200, 4'h2, 64'h0, 1'b1);
    add(1'b0, 64'd7,   4'h3, 64'h0, 1'b1);
    add(1'b0, 64'd15,  4'h4, 64'h0, 1'b1);
    add(1'b0, 64'h1_0000_0000, 4'h5, 64'h0, 1'b1);
    add(1'b0, 64'h1_0000_0011, 4'h6, 64'h0, 1'b1);
    // LOOKUP vectors.
    add(1'b1, 64'h8000_1000,   4'h7, 64'h3, 1'b0);
    add(1'b1, 64'h1_0000,      4'h8, 64'h1, 1'b0);
    add(1'b1, 64'h0FFF,        4'h9, 64'h1, 1'b0);
    add(1'b1, 64'hC000_0000,   4'hA, 64'h0, 1'b0);
    add(1'b1, 64'hBFFF_FFFF,   4'hB, 64'h3, 1'b0);
    add(1'b1, 64'h1000,        4'hC, 64'h0, 1'b0);
    add(1'b1, 64'h10,          4'hD, 64'h1, 1'b0);
    add(1'b1, 64'h1_FFFF,      4'hE, 64'h1, 1'b0);
    add(1'b1, 64'h2_0000,      4'hF, 64'h0, 1'b0);
    add(1'b1, 64'h1000_0000,   4'h0, 64'h4, 1'b0);
    add(1'b1, 64'h1000_1000,   4'h1, 64'h0, 1'b0);
    add(1'b1, 64'h4000_0000,   4'h2, 64'h4, 1'b0);
    add(1'b1, 64'h1_8000_1000, 4'h3, 64'h0, 1'b0);
    add(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 64'h0, 1'b0);

    // Reset state.
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_busy",      64'(busy_o), 64'd0);
    chk("rst_rsp_data",  rsp_data_o, 64'd0);
    chk("rst_rsp_err",   64'(rsp_err_o), 64'd0);
    chk("rst_rsp_id",    64'(rsp_id_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_req_ready", 64'(req_ready_o), 64'd1);

    foreach (vecs[n]) begin
      run_txn(vecs[n].op, vecs[n].addr, vecs[n].id, 0, data, err, rid, lat);
      chk($sformatf("vec%0d_data", n), data, vecs[n].exp_data);
      chk($sformatf("vec%0d_err", n), 64'(err), 64'(vecs[n].exp_err));
      chk($sformatf("vec%0d_id", n), 64'(rid), 64'(vecs[n].id));
      chk($sformatf("vec%0d_latency", n), 64'(lat), vecs[n].op ? 64'd4 : 64'd1);
    end

    // Backpressure with a second request queued behind the stalled response.
    req_valid_i = 1'b1; req_op_i = 1'b0; req_addr_i = 64'd1; req_id_i = 4'hA;
    @(posedge clk_i);
    #1;
    req_addr_i = 64'd2; req_id_i = 4'hB;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("stall_valid", 64'(rsp_valid_o), 64'd1);
      chk("stall_data", rsp_data_o, 64'h0080_0020_0802_0202);
      chk("stall_id", 64'(rsp_id_o), 64'hA);
      chk("stall_req_ready", 64'(req_ready_o), 64'd0);
      chk("stall_busy", 64'(busy_o), 64'd1);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("release_valid", 64'(rsp_valid_o), 64'd0);
    chk("release_req_ready", 64'(req_ready_o), 64'd1);
    chk("release_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("queued_valid", 64'(rsp_valid_o), 64'd1);
    chk("queued_data", rsp_data_o, 64'h800);
    chk("queued_id", 64'(rsp_id_o), 64'hB);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);

    // Reset during the second SCAN cycle aborts the lookup silently.
    req_valid_i = 1'b1; req_op_i = 1'b1; req_addr_i = 64'h8000_1000; req_id_i = 4'h3;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_valid", 64'(rsp_valid_o), 64'd0);
    chk("abort_req_ready", 64'(req_ready_o), 64'd0);
    chk("abort_id", 64'(rsp_id_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    chk("abort_no_response", 64'(seen), 64'd0);
    run_txn(1'b0, 64'd0, 4'h5, 0, data, err, rid, lat);
    chk("post_abort_data", data, 64'h3065);
    chk("post_abort_id", 64'(rid), 64'h5);

    // Random traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      op = 1'($urandom_range(0, 1));
      id = 4'($urandom_range(0, 15));
      if (op) begin
        case ($urandom_range(0, 2))
          0: begin b = C.ExecuteRegionAddrBase[$urandom_range(0, 3)]; l = 64'h0; end
          1: begin b = C.CachedRegionAddrBase[$urandom_range(0, 2)]; l = 64'h0; end
          default: begin b = C.NonIdempotentAddrBase[$urandom_range(0, 3)]; l = 64'h0; end
        endcase
        l = C.ExecuteRegionLength[$urandom_range(0, 3)];
        case ($urandom_range(0, 5))
          0: a = b - 64'd1;
          1: a = b;
          2: a = b + l - 64'd1;
          3: a = b + l;
          4: a = {$urandom(), $urandom()};
          default: a = {32'd0, $urandom()};
        endcase
        exp_d = model_lookup(a);
        run_txn(1'b1, a, id, $urandom_range(0, 2), data, err, rid, lat);
        chk($sformatf("rnd%0d_lookup_0x%0h", n, a), data, exp_d);
        chk($sformatf("rnd%0d_lookup_err", n), 64'(err), 64'd0);
        chk($sformatf("rnd%0d_lookup_lat", n), 64'(lat), 64'(m + 1));
      end else begin
        if ($urandom_range(0, 7) == 0) a = {$urandom(), $urandom()};
        else a = 64'($urandom_range(0, 127));
        exp_r = model_read(a);
        run_txn(1'b0, a, id, $urandom_range(0, 2), data, err, rid, lat);
        chk($sformatf("rnd%0d_read_%0d", n, a), data, exp_r[63:0]);
        chk($sformatf("rnd%0d_read_err", n), 64'(err), 64'(exp_r[64]));
        chk($sformatf("rnd%0d_read_lat", n), 64'(lat), 64'd1);
      end
      chk($sformatf("rnd%0d_id", n), 64'(rid), 64'(id));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
